// File: rtl/score_display_driver_if.sv
// Score display bus: binary score in, multiplexed 7-segment drive and
// BCD status out.
//   value_i     : binary score from the counter (BW bits)
//   seg_o       : segments {g,f,e,d,c,b,a}, active high
//   digit_sel_o : one-hot digit enable, 2'b01 = ones, 2'b10 = tens
//   tens_o      : BCD tens digit of the last completed conversion
//   ones_o      : BCD ones digit of the last completed conversion
//   busy_o      : conversion in progress
interface score_display_driver_if #(
    parameter int unsigned BW = 7
);
    logic [BW-1:0] value_i;
    logic [6:0]    seg_o;
    logic [1:0]    digit_sel_o;
    logic [3:0]    tens_o;
    logic [3:0]    ones_o;
    logic          busy_o;

    // Display driver side
    modport slave (
        input  value_i,
        output seg_o, digit_sel_o, tens_o, ones_o, busy_o
    );

    // Score source / observer side
    modport master (
        output value_i,
        input  seg_o, digit_sel_o, tens_o, ones_o, busy_o
    );
endinterface

// File: rtl/score_display_driver.sv
// Converts a 0-99 binary score to two BCD digits with a sequential
// double-dabble engine and time-multiplexes them onto one 7-segment bus.
// The displayed digits only change when a conversion completes.
//   clk_i : clock, all state on posedge
//   rst_i : asynchronous active-high reset
//   bus   : score_display_driver_if slave (value_i in; seg_o, digit_sel_o,
//           tens_o, ones_o, busy_o out, all registered)
module score_display_driver #(
    parameter int unsigned BW          = 7,
    parameter int unsigned REFRESH_DIV = 1000,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    score_display_driver_if.slave  bus
);
    localparam int unsigned MAX_VAL = 99;
    localparam int unsigned CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned ITW     = $clog2(BW);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  last_q, last_d;
    logic [BW-1:0]  bin_q, bin_d;
    logic [7:0]     bcd_q, bcd_d;
    logic [7:0]     adj;
    logic [ITW-1:0] iter_q, iter_d;
    logic [3:0]     tens_q, tens_d;
    logic [3:0]     ones_q, ones_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  ref_q, ref_d;
    logic [1:0]     sel_q, sel_d;
    logic [6:0]     seg_q, seg_d;
    logic [BW-1:0]  clamped;
    logic           wrap;

    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        case (d)
            4'd0:    seg_enc = 7'b0111111;
            4'd1:    seg_enc = 7'b0000110;
            4'd2:    seg_enc = 7'b1011011;
            4'd3:    seg_enc = 7'b1001111;
            4'd4:    seg_enc = 7'b1100110;
            4'd5:    seg_enc = 7'b1101101;
            4'd6:    seg_enc = 7'b1111101;
            4'd7:    seg_enc = 7'b0000111;
            4'd8:    seg_enc = 7'b1111111;
            4'd9:    seg_enc = 7'b1101111;
            default: seg_enc = 7'b0000000;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state, conversion datapath and display multiplexing
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        clamped = (bus.value_i > BW'(MAX_VAL)) ? BW'(MAX_VAL) : bus.value_i;

        // Add-3 correction applied before each shift
        adj = bcd_q;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;

        case (state_q)
            S_IDLE: begin
                if (clamped != last_q) begin
                    bin_d   = clamped;
                    bcd_d   = 8'd0;
                    last_d  = clamped;
                    iter_d  = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d  = 8'({adj, bin_q[BW-1]});
                bin_d  = BW'({bin_q, 1'b0});
                iter_d = iter_q + ITW'(1);
                if (iter_q == ITW'(BW - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                tens_d  = bcd_q[7:4];
                ones_d  = bcd_q[3:0];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);

        // Refresh divider; digit toggles on the wrap cycle
        wrap  = (ref_q == CW'(REFRESH_DIV - 1));
        ref_d = wrap ? '0 : ref_q + CW'(1);
        sel_d = wrap ? {sel_q[0], sel_q[1]} : sel_q;

        // Segments follow the digit being selected on this same edge
        if (sel_d[1]) seg_d = (LZ_BLANK && (tens_q == 4'd0)) ? 7'b0000000 : seg_enc(tens_q);
        else          seg_d = seg_enc(ones_q);
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= '0;
            bin_q  <= '0;
            bcd_q  <= 8'd0;
            iter_q <= '0;
            tens_q <= 4'd0;
            ones_q <= 4'd0;
            busy_q <= 1'b0;
            ref_q  <= '0;
            sel_q  <= 2'b01;
            seg_q  <= 7'b0111111;
        end else begin
            last_q <= last_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            iter_q <= iter_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            busy_q <= busy_d;
            ref_q  <= ref_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign bus.seg_o       = seg_q;
    assign bus.digit_sel_o = sel_q;
    assign bus.tens_o      = tens_q;
    assign bus.ones_o      = ones_q;
    assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_score_display_driver.sv
// Bench for score_display_driver: two instances (leading-zero blanking on
// and off) share clock, reset and score input; results are checked against
// decimal arithmetic and a cycle-count model of the digit scan.
module tb_score_display_driver;
    localparam int unsigned BW  = 7;
    localparam int unsigned DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    score_display_driver_if #(.BW(BW)) bus_b ();
    score_display_driver_if #(.BW(BW)) bus_z ();

    score_display_driver #(.BW(BW), .REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b)
    );
    score_display_driver #(.BW(BW), .REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_z (
        .clk_i(clk), .rst_i(rst), .bus(bus_z)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int ncyc   = 0;
    int busy_run = 0;
    int max_run  = 0;
    int cur_t  = 0;
    int cur_o  = 0;
    int last_c = 0;

    // Edges since reset release, used to predict the digit scan
    always @(posedge clk or posedge rst) begin
        if (rst) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input bit tens_sel, input int t, input int o, input bit lz);
        if (!tens_sel) return seg_of(o);
        if (lz && t == 0) return 7'b0000000;
        return seg_of(t);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (bus_b.busy_o === 1'b1) busy_run++;
        else busy_run = 0;
        if (busy_run > max_run) max_run = busy_run;
    endtask

    task automatic set_value(input int v);
        bus_b.value_i = BW'(v);
        bus_z.value_i = BW'(v);
    endtask

    task automatic chk_digits(input string tag, input int t, input int o, input bit busy);
        chk({tag, "_tens_b"}, 8'(bus_b.tens_o), 8'(t));
        chk({tag, "_ones_b"}, 8'(bus_b.ones_o), 8'(o));
        chk({tag, "_tens_z"}, 8'(bus_z.tens_o), 8'(t));
        chk({tag, "_ones_z"}, 8'(bus_z.ones_o), 8'(o));
        chk({tag, "_busy"},   8'(bus_b.busy_o), 8'(busy));
        chk({tag, "_busy_z"}, 8'(bus_z.busy_o), 8'(busy));
    endtask

    task automatic check_display(input int n);
        bit tsel;
        for (int i = 0; i < n; i++) begin
            step();
            tsel = ((ncyc / DIV) % 2) == 1;
            chk("sel_b", 8'(bus_b.digit_sel_o), tsel ? 8'h02 : 8'h01);
            chk("sel_z", 8'(bus_z.digit_sel_o), tsel ? 8'h02 : 8'h01);
            chk("seg_b", 8'(bus_b.seg_o), 8'(exp_seg(tsel, cur_t, cur_o, 1'b1)));
            chk("seg_z", 8'(bus_z.seg_o), 8'(exp_seg(tsel, cur_t, cur_o, 1'b0)));
        end
    endtask

    task automatic convert(input int v);
        int c;
        c = (v > 99) ? 99 : v;
        set_value(v);
        if (c == last_c) begin
            for (int i = 0; i < 3; i++) begin
                step();
                chk_digits("nochange", cur_t, cur_o, 1'b0);
            end
            return;
        end
        step();
        chk("capture_busy", 8'(bus_b.busy_o), 8'h01);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_digits("shifting", cur_t, cur_o, 1'b1);
        end
        step();
        cur_t  = c / 10;
        cur_o  = c % 10;
        last_c = c;
        chk_digits("result", cur_t, cur_o, 1'b0);
        check_display(2 * DIV + 1);
    endtask

    initial begin
        set_value(0);
        #1 rst = 1'b1;
        #1;
        chk_digits("reset", 0, 0, 1'b0);
        chk("reset_sel", 8'(bus_b.digit_sel_o), 8'h01);
        chk("reset_seg", 8'(bus_b.seg_o), 8'h3f);
        step();
        step();
        rst = 1'b0;

        // Idle with value 0: no conversion, blank/zero scan
        check_display(3 * DIV);
        chk_digits("idle0", 0, 0, 1'b0);

        convert(42);
        convert(99);
        convert(7);
        convert(120);
        chk_digits("clamp", 9, 9, 1'b0);

        for (int i = 0; i < 6; i++) convert(int'($urandom_range(0, 127)));

        // Change while busy: second conversion follows automatically
        if (last_c == 10) convert(33);
        max_run = 0;
        set_value(10);
        step();
        chk("cb_capture", 8'(bus_b.busy_o), 8'h01);
        step();
        step();
        set_value(57);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("cb_busy1", 8'(bus_b.busy_o), 8'h01);
        end
        step();
        chk_digits("cb_first", 1, 0, 1'b0);
        step();
        chk("cb_restart", 8'(bus_b.busy_o), 8'h01);
        for (int i = 0; i < 7; i++) begin
            step();
            chk_digits("cb_shift2", 1, 0, 1'b1);
        end
        step();
        cur_t = 5; cur_o = 7; last_c = 57;
        chk_digits("cb_second", 5, 7, 1'b0);
        chk("cb_maxrun", 8'(max_run), 8'd8);
        check_display(2 * DIV + 1);

        // Reset on shift iteration 4 of value 63
        set_value(63);
        step();
        chk("rm_capture", 8'(bus_b.busy_o), 8'h01);
        for (int i = 0; i < 4; i++) step();
        #2 rst = 1'b1;
        #1;
        chk_digits("rm_async", 0, 0, 1'b0);
        chk("rm_sel", 8'(bus_b.digit_sel_o), 8'h01);
        chk("rm_seg_b", 8'(bus_b.seg_o), 8'h3f);
        chk("rm_seg_z", 8'(bus_z.seg_o), 8'h3f);
        step();
        step();
        chk_digits("rm_held", 0, 0, 1'b0);
        rst = 1'b0;
        cur_t = 0; cur_o = 0; last_c = 0;
        convert(63);
        chk_digits("rm_final", 6, 3, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/score_display_driver.md
# score_display_driver

Downstream stage of the up/down score counter. Takes the 7-bit binary score and converts it to two BCD digits with a sequential double-dabble engine. It then time-multiplexes the digits onto one shared 7-segment bus with one-hot digit enables. It holds the last completed conversion on the display while a new conversion runs, so partial results never reach the pins.

## Interface
- BW, 7: width of value_i; fixed at 7 for 0-99 operation.
- REFRESH_DIV, 1000: clk_i cycles each digit stays active; minimum 2.
- LZ_BLANK, 1: 1 blanks the tens digit when it is 0; 0 shows a leading zero.

- clk_i  input  1  single clock; all state on posedge.
- rst_i  input  1  asynchronous, active-high reset.
- value_i  input  BW  binary score from the counter.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active high, registered.
- digit_sel_o  output  2  one-hot digit enable: 2'b01 = ones, 2'b10 = tens; registered.
- tens_o  output  4  BCD tens digit of the last completed conversion.
- ones_o  output  4  BCD ones digit of the last completed conversion.
- busy_o  output  1  high while a conversion is in progress.

## Operation
- Reset values (asynchronous):
  - state = IDLE, last_value = 0.
  - tens_o = 0, ones_o = 0, busy_o = 0.
  - refresh counter = 0, digit_sel_o = 2'b01, seg_o = 7'b0111111 ("0" on the ones digit).
- Input clamp: if value_i > 99, the captured value is 99.
- FSM states:
  - IDLE: if the clamped value_i differs from last_value, capture it into the shift register, clear the BCD accumulator, set last_value to it, set the iteration count to 0, and go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: per cycle, add 3 to each BCD nibble that is ≥5, then shift {bcd, bin} left by 1. After 7 iterations go to DONE.
  - DONE: load tens_o/ones_o from the accumulator, then return to IDLE.
- busy_o = 1 in SHIFT and DONE, 0 in IDLE.
- value_i changes while busy are ignored. On return to IDLE the compare against last_value starts a new conversion, so the final stable input is always displayed.
- Segment encoding (gfedcba):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110.
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111.
  - Nibbles above 9 cannot occur; encode them as 0000000.
- Refresh counter behaviour:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle the selected digit toggles (ones ↔ tens).
  - The counter runs independently of conversion activity.
- Every cycle, seg_o is loaded with the encoding of the digit that digit_sel_o is being loaded with, so segments and enable change on the same edge.
- Tens digit with LZ_BLANK=1 and tens=0: seg_o = 0000000 while the tens digit is selected; digit_sel_o still cycles normally.

## Timing
- Conversion latency, with the change seen in IDLE at edge k:
  - Edge k: capture.
  - Edges k+1..k+7: shift iterations.
  - Edge k+8: tens_o/ones_o update.
  - busy_o is high from after edge k until edge k+8; it is low again after edge k+8.
- Minimum spacing between two accepted conversions: 9 cycles.
- seg_o reflects new tens_o/ones_o from the edge after they update (1 cycle lag).
- Digit period: REFRESH_DIV cycles per digit, 2·REFRESH_DIV per full scan.
- Reset asserted mid-conversion: everything returns to reset values immediately and the partial result is discarded. After release, a nonzero value_i starts a fresh conversion from IDLE.
- value_i = 0 after reset: no conversion starts, because it matches last_value.

## Test plan
- Reset and idle, value_i = 0, no change:
  - Outputs hold the reset values; busy_o stays 0.
  - With REFRESH_DIV=4, digit_sel_o toggles every 4 cycles.
  - seg_o = 0000000 when tens is selected (LZ_BLANK=1) and 0111111 when ones is selected.
- value_i 0→42:
  - busy_o rises after the capture edge.
  - Exactly 8 cycles later tens_o=4, ones_o=2 and busy_o=0.
  - seg_o shows 1100110 on tens and 1011011 on ones.
- Boundaries:
  - value_i=99 gives 9/9, seg 1101111 on both digits.
  - value_i=120 clamps to 9/9.
  - value_i=7 gives 0/7; the tens digit is blanked with LZ_BLANK=1 and shows 0111111 with LZ_BLANK=0.
- Change during busy: value_i=10, then 57 on the third busy cycle:
  - The first result is 1/0.
  - A second conversion starts automatically on the cycle after returning to IDLE.
  - Final result is 5/7; busy_o is never high for more than 8 consecutive cycles per conversion.
- Reset mid-conversion: assert rst_i on SHIFT iteration 4 of value 63:
  - Outputs return to reset values asynchronously (before the next edge).
  - After release with value_i=63 held, the result is 6/3 exactly 8 cycles after the capture edge.
